button_led_ctrl: RTL and testbench
==================================

Name: button_led_ctrl

Overview:
Control block for the Nexys3 Button/Switch/LED datapath.
- Synchronises and debounces the raw Button and Switch pins.
- Detects button presses and steps a 4-state LED mode sequencer.
- Drives LED_B (mode pattern) and LED_S (debounced switch = "unlock" indicator).
- Sits directly between the board pins and the LEDs; replaces the direct pin-to-LED wiring.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable sampled cycles required before a debounced level changes (10 ms at 100 MHz); min 2
SLOW_DIV, 25_000_000, cycles per half-period in BLINK_SLOW (2 Hz blink at 100 MHz); min 1
FAST_DIV, 5_000_000, cycles per half-period in BLINK_FAST (10 Hz); min 1
CNT_W, 25, width of the debounce and blink counters; must hold max(DEBOUNCE_CYCLES, SLOW_DIV, FAST_DIV)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk at board level
Button  input  1  raw push button, asynchronous, active-high
Switch  input  1  raw slide switch, asynchronous; 1 = unlocked
LED_B  output  1  mode pattern LED
LED_S  output  1  debounced Switch level
mode  output  2  current sequencer state encoding
press_pulse  output  1  one-cycle strobe per accepted debounced press

Behaviour:
- Reset (reset=0, asynchronous): all flops clear. LED_B=0, LED_S=0, mode=OFF (2'd0), press_pulse=0, counters=0, debounced levels=0.
- Synchroniser: two-flop synchroniser per raw input; the sync output lags the pin by 2 cycles.
- Debounce, per input:
  - Counter clears whenever the sync value equals the stable value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sync value still differs, the stable value flips and the counter clears.
  - Any bounce back clears the counter; a glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Latency from a clean pin edge to the stable value change: 2+DEBOUNCE_CYCLES cycles.
- Press detect: press_pulse=1 for exactly one cycle, in the cycle after the debounced Button rises. Release produces no pulse.
- Mode FSM, advances only on press_pulse with debounced Switch=1:
  - Sequence: OFF(0) -> SOLID(1) -> BLINK_SLOW(2) -> BLINK_FAST(3) -> OFF(0), wrap-around.
  - mode updates one cycle after press_pulse.
  - With debounced Switch=0 (locked), presses still pulse press_pulse, but mode holds.
- LED_B per mode:
  - OFF: 0.
  - SOLID: 1.
  - BLINK_SLOW / BLINK_FAST: toggles every SLOW_DIV / FAST_DIV cycles respectively.
- Blink divider:
  - On any mode change, the blink counter clears and the phase is set to 1, so a blink mode starts with LED_B=1 the cycle mode changes.
  - LED_B is registered: it is valid in the same cycle the new mode is visible.
  - Divider wrap: the counter counts 0..DIV-1, and the phase toggles at the DIV-1 to 0 transition.
- LED_S: registered copy of the debounced Switch, one cycle after the stable value changes.
- Simultaneous events: a press arriving in the same cycle as a lock, i.e. the debounced Switch falling, is evaluated against the pre-update Switch value, so the press is accepted.
- Reset mid-operation: immediate return to reset values. A button held through reset deassertion must debounce again and generates a press only after it is re-detected rising.
  - Because the stable value restarts at 0, a held button produces a pulse 2+DEBOUNCE_CYCLES+1 cycles after reset deasserts.

Decomposition:
- Package btn_led_pkg:
  - mode encodings MODE_OFF/MODE_SOLID/MODE_BLINK_SLOW/MODE_BLINK_FAST (2-bit)
  - default DEBOUNCE_CYCLES, SLOW_DIV and FAST_DIV constants
- Sub-module debouncer (params DEBOUNCE_CYCLES, CNT_W; ports clk, reset, din, dout), containing both the synchroniser and the debounce counter; instantiated twice.
- FSM, press detect and blink divider live in the top.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, SLOW_DIV=8, FAST_DIV=2.
1. Reset: hold reset=0 with Button=1 and Switch=1 -> all outputs 0. Release reset -> LED_S=1 and press_pulse=1 at cycles 7 and 7 (2 sync + 4 debounce + 1 register), mode=1 at cycle 8.
2. Glitch rejection: Switch=1; Button high for 3 cycles then low -> press_pulse is never asserted and mode stays 0.
3. Full cycle: four clean presses (8 cycles high, 8 low each) -> mode 1,2,3,0 in order; exactly 4 press_pulse strobes; LED_B 0->1 at SOLID.
4. Blink timing: enter BLINK_SLOW -> LED_B=1 for 8 cycles, 0 for 8, repeating. Next press to BLINK_FAST -> LED_B restarts at 1 with 2-cycle half-periods.
5. Lock: Switch=0 then 3 presses -> 3 press_pulse strobes, mode unchanged, LED_S=0.
6. Reset mid-blink: assert reset=0 asynchronously while in BLINK_FAST -> LED_B=0 and mode=0 within the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/btn_led_pkg.sv
// Shared mode encodings and default timing constants for the button/LED controller.
package btn_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_SOLID      = 2'd1,
        MODE_BLINK_SLOW = 2'd2,
        MODE_BLINK_FAST = 2'd3
    } mode_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int SLOW_DIV_DEF        = 25_000_000;
    localparam int FAST_DIV_DEF        = 5_000_000;
    localparam int CNT_W_DEF           = 25;

    // The 2-bit encoding wraps naturally from BLINK_FAST back to OFF.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/button_led_ctrl_if.sv
// Pin-side bundle: raw button/switch inputs and the LED/status outputs.
interface button_led_ctrl_if;
   logic       Button;
   logic       Switch;
   logic       LED_B;
   logic       LED_S;
   logic [1:0] mode;
   logic       press_pulse;

   modport master (output Button, Switch, input LED_B, LED_S, mode, press_pulse);
   modport slave  (input Button, Switch, output LED_B, LED_S, mode, press_pulse);
endinterface

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output flips only
// after the synchronised input has differed for DEBOUNCE_CYCLES consecutive cycles.
module debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         // Any return to the stable level discards accumulated evidence.
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign dout = r_stable;
endmodule

// File: rtl/button_led_ctrl.sv
// Debounces Button/Switch, turns button presses into mode steps while unlocked,
// and drives the mode pattern LED plus the unlock indicator LED.
module button_led_ctrl
   import btn_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int SLOW_DIV        = SLOW_DIV_DEF,
   parameter int FAST_DIV        = FAST_DIV_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   button_led_ctrl_if.slave   bus
);
   localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

   // Index 0 is the button, index 1 the switch.
   logic [1:0] w_raw;
   logic [1:0] w_db;

   assign w_raw = {bus.Switch, bus.Button};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_deb
         debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_debouncer (
            .clk   (clk),
            .reset (reset),
            .din   (w_raw[gi]),
            .dout  (w_db[gi])
         );
      end
   endgenerate

   logic r_btn_prev;
   logic r_press;
   logic r_led_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_btn_prev <= 1'b0;
         r_press    <= 1'b0;
         r_led_s    <= 1'b0;
      end else begin
         r_btn_prev <= w_db[0];
         r_press    <= w_db[0] & ~r_btn_prev;
         r_led_s    <= w_db[1];
      end
   end

   mode_t            r_mode;
   mode_t            w_mode_next;
   logic [CNT_W-1:0] r_blink_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_div_last;
   logic             r_phase;
   logic             w_phase_next;
   logic             r_led_b;
   logic             w_led_b_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode      <= MODE_OFF;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_led_b     <= 1'b0;
      end else begin
         r_mode      <= w_mode_next;
         r_blink_cnt <= w_cnt_next;
         r_phase     <= w_phase_next;
         r_led_b     <= w_led_b_next;
      end
   end

   // The registered switch level is sampled before its own update, so a
   // press coinciding with a lock is still accepted.
   always_comb begin
      w_mode_next = r_mode;
      if (r_press && w_db[1]) begin
         w_mode_next = next_mode(r_mode);
      end
   end

   assign w_div_last = (r_mode == MODE_BLINK_SLOW) ? SLOW_LAST : FAST_LAST;

   always_comb begin
      w_cnt_next   = r_blink_cnt;
      w_phase_next = r_phase;
      if (w_mode_next != r_mode) begin
         w_cnt_next   = '0;
         w_phase_next = 1'b1;
      end else if (r_mode == MODE_BLINK_SLOW || r_mode == MODE_BLINK_FAST) begin
         if (r_blink_cnt == w_div_last) begin
            w_cnt_next   = '0;
            w_phase_next = ~r_phase;
         end else begin
            w_cnt_next = r_blink_cnt + CNT_W'(1);
         end
      end
   end

   // Decoded from next-state values so LED_B lands in the same cycle as mode.
   always_comb begin
      w_led_b_next = 1'b0;
      case (w_mode_next)
         MODE_OFF:   w_led_b_next = 1'b0;
         MODE_SOLID: w_led_b_next = 1'b1;
         default:    w_led_b_next = w_phase_next;
      endcase
   end

   assign bus.LED_B       = r_led_b;
   assign bus.LED_S       = r_led_s;
   assign bus.mode        = r_mode;
   assign bus.press_pulse = r_press;
endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl with short debounce/blink constants.
module tb_button_led_ctrl;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;
   int   pulse_cnt;
   int   snap;

   button_led_ctrl_if bus ();

   button_led_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .SLOW_DIV        (8),
      .FAST_DIV        (2),
      .CNT_W           (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.press_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hi, input int lo);
      bus.Button = 1'b1;
      cycles(hi);
      bus.Button = 1'b0;
      cycles(lo);
   endtask

   task automatic do_reset(input logic btn, input logic sw);
      @(negedge clk);
      bus.Button = btn;
      bus.Switch = sw;
      reset = 1'b0;
      cycles(3);
      reset = 1'b1;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      pulse_cnt = 0;
      reset      = 1'b0;
      bus.Button = 1'b1;
      bus.Switch = 1'b1;

      // 1: reset with both inputs held high, then release
      cycles(4);
      check("rst_led_b", 32'(bus.LED_B), 0);
      check("rst_led_s", 32'(bus.LED_S), 0);
      check("rst_mode", 32'(bus.mode), 0);
      check("rst_pulse", 32'(bus.press_pulse), 0);
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("t1_pulse_c%0d", k), 32'(bus.press_pulse), (k == 7) ? 1 : 0);
         check($sformatf("t1_led_s_c%0d", k), 32'(bus.LED_S), (k >= 7) ? 1 : 0);
         check($sformatf("t1_mode_c%0d", k), 32'(bus.mode), (k >= 8) ? 1 : 0);
      end
      check("t1_led_b_solid", 32'(bus.LED_B), 1);

      // 2: 3-cycle glitch must be rejected
      do_reset(1'b0, 1'b1);
      cycles(10);
      check("t2_led_s", 32'(bus.LED_S), 1);
      snap = pulse_cnt;
      press(3, 12);
      check("t2_pulses", 32'(pulse_cnt - snap), 0);
      check("t2_mode", 32'(bus.mode), 0);

      // 3: full sequence of four presses
      snap = pulse_cnt;
      press(8, 8);
      check("t3_mode1", 32'(bus.mode), 1);
      check("t3_led_b_solid", 32'(bus.LED_B), 1);
      press(8, 8);
      check("t3_mode2", 32'(bus.mode), 2);
      press(8, 8);
      check("t3_mode3", 32'(bus.mode), 3);
      press(8, 8);
      check("t3_mode0", 32'(bus.mode), 0);
      check("t3_led_b_off", 32'(bus.LED_B), 0);
      check("t3_pulses", 32'(pulse_cnt - snap), 4);

      // 4: blink timing on entry to BLINK_SLOW and BLINK_FAST
      press(8, 8);
      bus.Button = 1'b1;
      cycles(8);
      bus.Button = 1'b0;
      check("t4_mode_slow", 32'(bus.mode), 2);
      for (int j = 0; j < 16; j++) begin
         check($sformatf("t4_slow_j%0d", j), 32'(bus.LED_B), (j < 8) ? 1 : 0);
         @(negedge clk);
      end
      bus.Button = 1'b1;
      cycles(8);
      bus.Button = 1'b0;
      check("t4_mode_fast", 32'(bus.mode), 3);
      for (int j = 0; j < 8; j++) begin
         check($sformatf("t4_fast_j%0d", j), 32'(bus.LED_B), (((j / 2) % 2) == 0) ? 1 : 0);
         @(negedge clk);
      end

      // 6: asynchronous reset in BLINK_FAST, mid low-phase of clk
      check("t6_pre_mode", 32'(bus.mode), 3);
      #2;
      reset = 1'b0;
      #1;
      check("t6_led_b", 32'(bus.LED_B), 0);
      check("t6_mode", 32'(bus.mode), 0);
      check("t6_led_s", 32'(bus.LED_S), 0);
      cycles(3);
      reset = 1'b1;

      // 5: locked switch still pulses but holds the mode
      cycles(10);
      press(8, 8);
      check("t5_mode_unlocked", 32'(bus.mode), 1);
      bus.Switch = 1'b0;
      cycles(10);
      check("t5_led_s", 32'(bus.LED_S), 0);
      snap = pulse_cnt;
      press(8, 8);
      press(8, 8);
      press(8, 8);
      check("t5_pulses", 32'(pulse_cnt - snap), 3);
      check("t5_mode_held", 32'(bus.mode), 1);
      check("t5_led_b", 32'(bus.LED_B), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
